// File: rtl/cmda_dly_pkg.sv
// rtl/cmda_dly_pkg.sv - shared types, constants and index helpers for the cmd/addr delay sequencer
// Used by cmd_addr_dly_seq and cmda_dly_table; CMDA_DLY_DIRTY_ONLY_EN changes what callers pass as eligible.
package cmda_dly_pkg;

  localparam int DLY_W      = 8;
  localparam int DLY_ADDR_W = 5;

  localparam logic [DLY_ADDR_W-1:0] CMD_BASE = 5'd24;
  localparam logic [DLY_ADDR_W-1:0] CMD_LAST = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SET,
    ST_WAIT
  } seq_state_t;

  // Address lines occupy the bottom of the index space, command lines sit at CMD_BASE..CMD_LAST.
  function automatic logic [31:0] valid_mask(input int addr_num);
    logic [31:0] m;
    for (int i = 0; i < 32; i++)
      m[i] = (i < addr_num) || ((i >= int'(CMD_BASE)) && (i <= int'(CMD_LAST)));
    return m;
  endfunction

  // Lowest eligible index at or above 'from'; the MSB of the result flags a hit.
  function automatic logic [DLY_ADDR_W:0] next_idx(input logic [DLY_ADDR_W:0] from,
                                                   input logic [31:0]         elig);
    logic [DLY_ADDR_W:0] res;
    res = '0;
    for (int i = 31; i >= 0; i--)
      if ((6'(i) >= from) && elig[i])
        res = {1'b1, 5'(i)};
    return res;
  endfunction

endpackage

// File: rtl/cmda_dly_table.sv
// rtl/cmda_dly_table.sv - 32x8 delay table with replay and registered readback ports
// Dirty bits exist only when CMDA_DLY_DIRTY_ONLY_EN is defined.
module cmda_dly_table
  import cmda_dly_pkg::*;
#(
  parameter int               ADDRESS_NUMBER = 15,
  parameter logic [DLY_W-1:0] DEFAULT_DLY    = 8'h00
) (
  input  logic                  clk_div,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DLY_ADDR_W-1:0] wr_addr,
  input  logic [DLY_W-1:0]      wr_data,
  input  logic [DLY_ADDR_W-1:0] rep_addr,
  output logic [DLY_W-1:0]      rep_data,
  input  logic [DLY_ADDR_W-1:0] rd_addr,
  output logic [DLY_W-1:0]      rd_data
`ifdef CMDA_DLY_DIRTY_ONLY_EN
  ,
  input  logic                  clr_en,
  input  logic [DLY_ADDR_W-1:0] clr_addr,
  output logic [31:0]           dirty
`endif
);

  localparam logic [31:0] VALID = valid_mask(ADDRESS_NUMBER);

  logic [DLY_W-1:0] mem [32];

  // Unused indices keep their reset value but are never visible on readback.
  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= DEFAULT_DLY;
      rd_data <= '0;
    end else begin
      if (wr_en && VALID[wr_addr])
        mem[wr_addr] <= wr_data;
      rd_data <= VALID[rd_addr] ? mem[rd_addr] : '0;
    end
  end

  assign rep_data = mem[rep_addr];

`ifdef CMDA_DLY_DIRTY_ONLY_EN
  // A load in the same cycle as the write consumes the forwarded value, so clear wins.
  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      dirty <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (clr_en && (clr_addr == 5'(i)))
          dirty[i] <= 1'b0;
        else if (wr_en && VALID[i] && (wr_addr == 5'(i)))
          dirty[i] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cmd_addr_dly_seq.sv
// rtl/cmd_addr_dly_seq.sv - replays the cmd/addr ODELAY table into the PHY, then pulses set
// Optional CMDA_DLY_DIRTY_ONLY_EN: replay only entries written since their last load.
module cmd_addr_dly_seq
  import cmda_dly_pkg::*;
#(
  parameter int               ADDRESS_NUMBER = 15,
  parameter logic [DLY_W-1:0] DEFAULT_DLY    = 8'h00,
  parameter int               SETTLE_CYCLES  = 2
) (
  input  logic                  clk_div,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DLY_ADDR_W-1:0] wr_addr,
  input  logic [DLY_W-1:0]      wr_data,
  output logic                  wr_ready,
  input  logic [DLY_ADDR_W-1:0] rd_addr,
  output logic [DLY_W-1:0]      rd_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DLY_ADDR_W-1:0] dly_addr,
  output logic [DLY_W-1:0]      dly_data,
  output logic                  ld_delay,
  output logic                  set
);

  localparam logic [31:0] VALID  = valid_mask(ADDRESS_NUMBER);
  localparam logic [3:0]  SETTLE = 4'(SETTLE_CYCLES);

  seq_state_t state, state_nxt;
  logic [DLY_ADDR_W-1:0] idx, idx_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  ld_nxt, set_nxt, done_nxt;
  logic [DLY_ADDR_W-1:0] addr_nxt;
  logic [DLY_W-1:0]      data_nxt;

  logic                  wr_acc;
  logic                  launch;
  logic [DLY_ADDR_W:0]   from;
  logic [31:0]           elig;
  logic                  hit;
  logic [DLY_ADDR_W-1:0] sel;
  logic [DLY_W-1:0]      rep_data;

  assign wr_acc = wr_en & wr_ready;
  assign launch = ((state == ST_IDLE) && start) || (state == ST_LOAD);
  assign from   = (state == ST_IDLE) ? '0 : ({1'b0, idx} + 6'd1);

`ifdef CMDA_DLY_DIRTY_ONLY_EN
  logic [31:0] dirty;
  logic [31:0] wr_hot;
  // A write landing with start must count as dirty for the first search.
  assign wr_hot = wr_acc ? (32'd1 << wr_addr) : '0;
  assign elig   = VALID & (dirty | wr_hot);
`else
  assign elig   = VALID;
`endif

  assign {hit, sel} = next_idx(from, elig);

  cmda_dly_table #(
    .ADDRESS_NUMBER (ADDRESS_NUMBER),
    .DEFAULT_DLY    (DEFAULT_DLY)
  ) u_table (
    .clk_div  (clk_div),
    .rst      (rst),
    .wr_en    (wr_acc),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rep_addr (sel),
    .rep_data (rep_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`ifdef CMDA_DLY_DIRTY_ONLY_EN
    ,
    .clr_en   (ld_nxt),
    .clr_addr (sel),
    .dirty    (dirty)
`endif
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    ld_nxt    = 1'b0;
    set_nxt   = 1'b0;
    done_nxt  = 1'b0;
    addr_nxt  = dly_addr;
    data_nxt  = dly_data;
    case (state)
      ST_IDLE, ST_LOAD: begin
        if (launch) begin
          if (hit) begin
            state_nxt = ST_LOAD;
            idx_nxt   = sel;
            ld_nxt    = 1'b1;
            addr_nxt  = sel;
            // Forward a write accepted alongside start; the array only updates at this edge.
            data_nxt  = (wr_acc && (wr_addr == sel)) ? wr_data : rep_data;
          end else begin
            state_nxt = ST_SET;
            set_nxt   = 1'b1;
          end
        end
      end
      ST_SET: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = SETTLE;
      end
      ST_WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      cnt      <= '0;
      dly_addr <= '0;
      dly_data <= '0;
      ld_delay <= 1'b0;
      set      <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      wr_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      dly_addr <= addr_nxt;
      dly_data <= data_nxt;
      ld_delay <= ld_nxt;
      set      <= set_nxt;
      done     <= done_nxt;
      busy     <= (state_nxt != ST_IDLE);
      wr_ready <= (state_nxt == ST_IDLE);
    end
  end

endmodule
